gol_display_scan: RTL and testbench
===================================

GOL_DISPLAY_SCAN -- requirements
Module: gol_display_scan

Interface
REQ-001 Parameter CLK_DIV, default 1000: clock cycles each row is lit; legal range 1..65535.
REQ-002 Parameter FRAMES_PER_GEN, default 30: completed frames per gen_step pulse; legal range 1..255.
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts row_sel and col_data at the pins.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 grid_in  input  64  current life grid; cell (r,c) = bit 8r+c.
REQ-007 load  input  1  sample grid_in into the pending buffer this cycle.
REQ-008 enable  input  1  1 = scan display, 0 = blank and idle.
REQ-009 row_sel  output  8  one-hot lit row; bit r = row r.
REQ-010 col_data  output  8  column bits of lit row; bit c = cell (r,c).
REQ-011 frame_done  output  1  one-cycle pulse per completed frame.
REQ-012 gen_step  output  1  one-cycle pulse every FRAMES_PER_GEN frames; advances upstream generation.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Block shall hold three states: IDLE, BLANK, SCAN.
REQ-015 IDLE: enable=1 -> BLANK with row=0; otherwise stay.
REQ-016 BLANK shall last exactly 1 cycle, then go to SCAN with the same row.
REQ-017 SCAN shall last exactly CLK_DIV cycles. It then goes to BLANK with row+1, and row 7 wraps to 0.
REQ-018 In any state, enable=0 shall force IDLE on the next edge, with row reset to 0 and all counters cleared. The pending buffer shall be preserved.
REQ-019 Frame length shall be 8*(CLK_DIV+1) cycles.
REQ-020 Frame boundary = edge entering BLANK with row=0 (from IDLE or from SCAN row 7).
REQ-021 load=1 on any edge shall copy grid_in to the pending buffer and set pending_valid.
REQ-022 At a frame boundary with pending_valid=1, the pending buffer shall be copied to the display register and pending_valid cleared.
REQ-023 load=1 on the boundary edge itself shall copy grid_in directly to the display register and leave pending_valid=0.
REQ-024 The display register shall change only at frame boundaries; no frame shows mixed grids.
REQ-025 Multiple loads within one frame: the last one wins.
REQ-026 In SCAN, row_sel shall be one-hot of row and col_data = display[8*row+7:8*row]; in IDLE and BLANK, both shall be 0.
REQ-027 Polarity: when ACTIVE_LOW=1, REQ-026 values shall be bitwise inverted.
REQ-028 row_sel, col_data, frame_done, gen_step and busy shall be driven directly from flops, with no combinational path from inputs.
REQ-029 frame_done shall be high exactly during the BLANK cycle that follows SCAN row 7; it shall not assert when entering from IDLE.
REQ-030 A frame counter (8 bit) shall increment on each frame_done. When it reaches FRAMES_PER_GEN, gen_step shall pulse coincident with frame_done and the counter return to 0.

Reset
REQ-031 reset shall force state IDLE, row 0, div counter 0, frame counter 0 and pending_valid 0.
REQ-032 reset shall clear the display register and pending buffer to 64'h0.
REQ-033 During reset: row_sel=0, col_data=0, frame_done=0, gen_step=0, busy=0, all before ACTIVE_LOW inversion.
REQ-034 Reset asserted mid-frame shall take effect immediately, without waiting for a frame or row boundary.

Structure
REQ-035 Package gol_pkg shall hold: scan_state_t enum {IDLE, BLANK, SCAN}; GRID_W=64; ROW_W=8; NUM_ROWS=8.
REQ-036 Sub-module tick_divider (parameter CLK_DIV) shall count SCAN cycles and emit a last-cycle strobe. It shall be cleared on reset and whenever not in SCAN.

Verification (bench uses CLK_DIV=4, FRAMES_PER_GEN=2)
REQ-037 Reset released, enable=0 for 20 cycles -> row_sel=0, col_data=0, busy=0 throughout.
REQ-038 load with grid_in=64'h8040201008040201, then enable=1 -> 1 BLANK cycle, then row r lit 4 cycles each with col_data=8'h01<<r; 1 BLANK between rows; frame_done high on cycle 41 after the BLANK entry.
REQ-039 Mid-frame load of 64'hFFFF_FFFF_FFFF_FFFF during row 3 -> rows 3..7 still show the old grid; the next frame shows col_data=8'hFF on every row.
REQ-040 Run 4 frames -> 4 frame_done pulses; gen_step on the 2nd and 4th only, each coincident with frame_done.
REQ-041 enable dropped during SCAN row 5 -> next cycle IDLE, outputs 0. Re-enable -> restarts at row 0 with the preserved pending grid, and no frame_done on entry.
REQ-042 Reset asserted mid-SCAN, with ACTIVE_LOW=1 build -> row_sel=8'hFF and col_data=8'hFF immediately; the display register reads 0 after release.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life LED matrix scanner.
// Row indices are 3 bits wide and address an 8x8 grid packed row-major into 64 bits.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SCAN
    } scan_state_t;

    localparam int GRID_W    = 64;
    localparam int ROW_W     = 8;
    localparam int NUM_ROWS  = 8;
    localparam int ROW_IDX_W = 3;

    function automatic logic [ROW_W-1:0] row_onehot(input logic [ROW_IDX_W-1:0] row);
        return ROW_W'(1) << row;
    endfunction

endpackage

// File: rtl/gol_display_scan_tick_divider.sv
// Counts the cycles a row stays lit and strobes on the last one.
// The counter sits at zero whenever the scanner is not in SCAN.
module tick_divider #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic last_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = run_i && (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = '0;
        if (run_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gol_display_scan.sv
// Multiplexed 8x8 LED scanner: lights one row at a time with a blank gap between rows,
// double-buffers the incoming grid so a frame never mixes two generations.
module gol_display_scan
    import gol_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int FRAMES_PER_GEN = 30,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid_in,
    input  logic              load,
    input  logic              enable,
    output logic [ROW_W-1:0]  row_sel,
    output logic [ROW_W-1:0]  col_data,
    output logic              frame_done,
    output logic              gen_step,
    output logic              busy
);

    // Polarity is folded into the output flops so the pins stay pure register outputs.
    localparam logic [ROW_W-1:0] POL_MASK = {ROW_W{ACTIVE_LOW}};

    scan_state_t           state_q, state_d;
    logic [ROW_IDX_W-1:0]  row_q, row_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [GRID_W-1:0]     pending_q, pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [GRID_W-1:0]     display_q, display_d;
    logic [ROW_W-1:0]      row_sel_q, row_sel_d;
    logic [ROW_W-1:0]      col_data_q, col_data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  gen_step_q, gen_step_d;
    logic                  busy_q, busy_d;
    logic                  boundary;
    logic                  scan_run;
    logic                  row_last;

    assign scan_run = enable && (state_q == SCAN);

    tick_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .run_i (scan_run),
        .last_o(row_last)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        gen_step_d   = 1'b0;
        boundary     = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            row_d       = '0;
            frame_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    row_d    = '0;
                    boundary = 1'b1;
                end
                BLANK: begin
                    state_d = SCAN;
                end
                SCAN: begin
                    if (row_last) begin
                        state_d = BLANK;
                        row_d   = row_q + 1'b1;
                        if (row_q == ROW_IDX_W'(NUM_ROWS - 1)) begin
                            boundary     = 1'b1;
                            frame_done_d = 1'b1;
                            if (frame_cnt_q == 8'(FRAMES_PER_GEN - 1)) begin
                                gen_step_d  = 1'b1;
                                frame_cnt_d = '0;
                            end else begin
                                frame_cnt_d = frame_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = '0;
                end
            endcase
        end
    end

    // A load landing on the boundary edge bypasses the pending buffer entirely.
    always_comb begin
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        display_d    = display_q;
        if (load) begin
            pending_d    = grid_in;
            pend_valid_d = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                display_d    = grid_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                display_d    = pending_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        row_sel_d  = POL_MASK;
        col_data_d = POL_MASK;
        if (state_d == SCAN) begin
            row_sel_d  = row_onehot(row_d) ^ POL_MASK;
            col_data_d = display_d[int'(row_d) * ROW_W +: ROW_W] ^ POL_MASK;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            frame_cnt_q  <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            display_q    <= '0;
            row_sel_q    <= POL_MASK;
            col_data_q   <= POL_MASK;
            frame_done_q <= 1'b0;
            gen_step_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            frame_cnt_q  <= frame_cnt_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            display_q    <= display_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
            gen_step_q   <= gen_step_d;
            busy_q       <= busy_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign gen_step   = gen_step_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gol_display_scan.sv
// Scoreboard bench: stimulus pushes cycle-stamped expected outputs, a negedge monitor
// pops and compares them against an active-high and an active-low build side by side.
module tb_gol_display_scan;

    localparam int CLK_DIV = 4;
    localparam int FPG     = 2;
    localparam int PER     = CLK_DIV + 1;
    localparam int FRAME   = 8 * PER;

    localparam logic [63:0] G1  = 64'h8040_2010_0804_0201;
    localparam logic [63:0] GFF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] G2  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] G3  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] G4  = 64'h55AA_55AA_0F0F_F0F0;
    localparam logic [63:0] G5  = 64'h1122_3344_5566_7788;

    typedef struct {
        int         stamp;
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fd;
        logic       gs;
        logic       bsy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        enable;
    logic [63:0] grid_in;
    logic [7:0]  rs_hi, cd_hi, rs_lo, cd_lo;
    logic        fd_hi, gs_hi, bsy_hi, fd_lo, gs_lo, bsy_lo;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gol_display_scan #(
        .CLK_DIV(CLK_DIV), .FRAMES_PER_GEN(FPG), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .reset(reset), .grid_in(grid_in), .load(load), .enable(enable),
        .row_sel(rs_hi), .col_data(cd_hi), .frame_done(fd_hi), .gen_step(gs_hi), .busy(bsy_hi)
    );

    gol_display_scan #(
        .CLK_DIV(CLK_DIV), .FRAMES_PER_GEN(FPG), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .reset(reset), .grid_in(grid_in), .load(load), .enable(enable),
        .row_sel(rs_lo), .col_data(cd_lo), .frame_done(fd_lo), .gen_step(gs_lo), .busy(bsy_lo)
    );

    task automatic check(input string name, input int stamp, input logic [18:0] act, input logic [18:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got rs=%h cd=%h fd=%b gs=%b busy=%b want rs=%h cd=%h fd=%b gs=%b busy=%b",
                     name, stamp, act[18:11], act[10:3], act[2], act[1], act[0],
                     exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_sample stamp=%0d now=%0d", e.stamp, cyc);
        end
        while (sb.size() > 0 && sb[0].stamp == cyc) begin
            e = sb.pop_front();
            check("outputs_active_high", cyc, {rs_hi, cd_hi, fd_hi, gs_hi, bsy_hi},
                  {e.rs, e.cd, e.fd, e.gs, e.bsy});
            check("outputs_active_low", cyc, {rs_lo, cd_lo, fd_lo, gs_lo, bsy_lo},
                  {~e.rs, ~e.cd, e.fd, e.gs, e.bsy});
        end
    end

    task automatic push(input int stamp, input logic [7:0] rs, input logic [7:0] cd,
                        input logic fd, input logic gs, input logic bsy);
        exp_t e;
        e.stamp = stamp; e.rs = rs; e.cd = cd; e.fd = fd; e.gs = gs; e.bsy = bsy;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int stamp);
        push(stamp, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // n cycles of a frame starting at its first BLANK; fd/gs only ever on that first cycle.
    task automatic expect_frame(input int s, input logic [63:0] g, input logic fd_first,
                                input logic gs_first, input int n);
        for (int k = 0; k < n; k++) begin
            int r;
            r = k / PER;
            if (k % PER == 0)
                push(s + k, 8'h00, 8'h00, (k == 0) ? fd_first : 1'b0, (k == 0) ? gs_first : 1'b0, 1'b1);
            else
                push(s + k, 8'(1 << r), g[8*r +: 8], 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic drive_load(input logic [63:0] g);
        grid_in = g;
        load    = 1'b1;
        $display("[TB] cyc=%0d load grid=%h", cyc, g);
        step();
        load = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int s1, s2, s3, s4, s5, s6, s7, s8;
        reset = 1'b1; enable = 1'b0; load = 1'b0; grid_in = '0;
        step(); step();
        push_idle(cyc);
        reset = 1'b0;
        $display("[TB] cyc=%0d reset released, idle with enable=0", cyc);
        for (int i = 0; i < 20; i++) begin
            step();
            push_idle(cyc);
        end

        step(); grid_in = G1; load = 1'b1; push_idle(cyc);
        $display("[TB] cyc=%0d load grid=%h", cyc, G1);
        step(); load = 1'b0; enable = 1'b1; push_idle(cyc);
        $display("[TB] cyc=%0d enable=1", cyc);
        s1 = cyc + 1;
        expect_frame(s1, G1, 1'b0, 1'b0, FRAME);
        s2 = s1 + FRAME;
        expect_frame(s2, GFF, 1'b1, 1'b0, FRAME);
        goto_cyc(s1 + 3 * PER + 1);
        drive_load(GFF);

        s3 = s2 + FRAME;
        expect_frame(s3, G3, 1'b1, 1'b1, FRAME);
        goto_cyc(s2 + 8);
        drive_load(G2);
        goto_cyc(s2 + 20);
        drive_load(G3);

        s4 = s3 + FRAME;
        expect_frame(s4, G4, 1'b1, 1'b0, FRAME);
        goto_cyc(s4 - 1);
        drive_load(G4);

        s5 = s4 + FRAME;
        expect_frame(s5, G4, 1'b1, 1'b1, 5 * PER + 2);
        for (int i = 5 * PER + 2; i <= 5 * PER + 11; i++) push_idle(s5 + i);
        goto_cyc(s5 + PER);
        drive_load(G5);
        goto_cyc(s5 + 5 * PER + 1);
        enable = 1'b0;
        $display("[TB] cyc=%0d enable=0 during row 5", cyc);
        goto_cyc(s5 + 5 * PER + 11);
        enable = 1'b1;
        $display("[TB] cyc=%0d enable=1 again", cyc);
        s6 = cyc + 1;
        expect_frame(s6, G5, 1'b0, 1'b0, FRAME);

        s7 = s6 + FRAME;
        expect_frame(s7, G5, 1'b1, 1'b0, 2 * PER + 2);
        for (int i = 2 * PER + 2; i <= 2 * PER + 4; i++) push_idle(s7 + i);
        goto_cyc(s7 + 2 * PER + 2);
        reset = 1'b1;
        $display("[TB] cyc=%0d reset asserted mid-scan", cyc);
        goto_cyc(s7 + 2 * PER + 4);
        reset = 1'b0;
        $display("[TB] cyc=%0d reset released with enable=1", cyc);
        s8 = cyc + 1;
        expect_frame(s8, 64'h0, 1'b0, 1'b0, FRAME);
        push(s8 + FRAME, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        push_idle(s8 + FRAME + 1);
        goto_cyc(s8 + FRAME);
        enable = 1'b0;
        $display("[TB] cyc=%0d enable=0", cyc);
        goto_cyc(s8 + FRAME + 2);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
